// File: rtl/lock_key_loader_if.sv
// Serial NVM/OTP read port carrying key and parity bits.
// Ports: nvm_valid/nvm_bit from the NVM, nvm_ready from the loader.
interface lock_key_loader_if;
    logic nvm_valid;
    logic nvm_bit;
    logic nvm_ready;

    modport master (
        output nvm_valid,
        output nvm_bit,
        input  nvm_ready
    );

    modport slave (
        input  nvm_valid,
        input  nvm_bit,
        output nvm_ready
    );
endinterface

// File: rtl/lock_key_loader.sv
// Serial key loader feeding the keyIn_0_* inputs of a locked netlist.
// Ports: clk/rst, start/lock requests, nvm (slave read port),
// key_out/key_valid/key_error/err_code/busy/locked status.
module lock_key_loader #(
    parameter int KEY_WIDTH = 16,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 lock,
    lock_key_loader_if.slave     nvm,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 key_error,
    output logic [1:0]           err_code,
    output logic                 busy,
    output logic                 locked
);

    localparam int BW = $clog2(KEY_WIDTH + 1);
    localparam logic [BW-1:0]    LAST = BW'(KEY_WIDTH);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t state;
    state_t next;

    logic [KEY_WIDTH-1:0] shadow;
    logic [BW-1:0]        bit_cnt;
    logic [CNT_W-1:0]     tmo_cnt;
    logic                 par;

    logic beat;
    logic start_ok;
    logic parity_ok;
    logic tmo_hit;

    // nvm_ready is exactly "state is LOAD", so the beat uses state directly.
    assign beat = nvm.nvm_valid && (state == LOAD);

    // Lock wins over start in DONE; a frozen key can never be reloaded.
    assign start_ok = start && ((state == IDLE) || (state == ERROR) ||
                      ((state == DONE) && !locked && !lock));

    assign parity_ok = ~(^shadow ^ par);
    assign tmo_hit   = (tmo_cnt == TMO);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state logic
    always_comb begin
        next = state;
        unique case (state)
            IDLE, ERROR, DONE: begin
                if (start_ok) begin
                    next = LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (bit_cnt == LAST) begin
                        next = CHECK;
                    end
                end else if (tmo_hit) begin
                    next = ERROR;
                end
            end
            CHECK: begin
                next = parity_ok ? DONE : ERROR;
            end
            default: next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        nvm.nvm_ready = 1'b0;
        busy          = 1'b0;
        unique case (state)
            LOAD: begin
                nvm.nvm_ready = 1'b1;
                busy          = 1'b1;
            end
            CHECK: begin
                busy = 1'b1;
            end
            default: begin
                nvm.nvm_ready = 1'b0;
                busy          = 1'b0;
            end
        endcase
    end

    // Registered datapath and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out   <= '0;
            key_valid <= 1'b0;
            key_error <= 1'b0;
            err_code  <= 2'b00;
            locked    <= 1'b0;
            shadow    <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            par       <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ERROR, DONE: begin
                    if (start_ok) begin
                        key_out   <= '0;
                        key_valid <= 1'b0;
                        key_error <= 1'b0;
                        err_code  <= 2'b00;
                        shadow    <= '0;
                        bit_cnt   <= '0;
                        tmo_cnt   <= '0;
                        par       <= 1'b0;
                    end
                    if ((state == DONE) && lock) begin
                        locked <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        tmo_cnt <= '0;
                        if (bit_cnt == LAST) begin
                            par <= nvm.nvm_bit;
                        end else begin
                            // Shift in at the MSB so beat 0 lands in bit 0.
                            shadow  <= {nvm.nvm_bit,
                                        shadow[KEY_WIDTH-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        key_error <= 1'b1;
                        err_code  <= 2'b10;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (parity_ok) begin
                        key_out   <= shadow;
                        key_valid <= 1'b1;
                    end else begin
                        key_error <= 1'b1;
                        err_code  <= 2'b01;
                    end
                end
                default: begin
                    key_out <= '0;
                end
            endcase
        end
    end

endmodule
